// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper slice.
// Holds the FSM state encoding and the display-driven limits.
package score_pkg;

    localparam int unsigned SCORE_W       = 7;
    localparam int unsigned MAX_SCORE_DEF = 99;
    localparam int unsigned BONUS_PTS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        COMMIT = 2'd2,
        OVER   = 2'd3
    } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score outputs of the score keeper.
// master drives events and reads scores; slave is the keeper.
interface score_keeper_if
    import score_pkg::*;
();
    logic               start;
    logic               point;
    logic               bonus;
    logic               game_over;
    logic               clr_high;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_high;
    logic               new_record;
    logic               playing;

    modport master (
        output start, point, bonus, game_over, clr_high,
        input  score, score_high, new_record, playing
    );

    modport slave (
        input  start, point, bonus, game_over, clr_high,
        output score, score_high, new_record, playing
    );
endinterface

// File: rtl/score_sat_add.sv
// Saturating score adder: score + inc clamped to MAX_SCORE.
// Sum is formed one bit wider so it can never wrap.
module score_sat_add
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
    input  logic [SCORE_W-1:0] score_i,
    input  logic [SCORE_W-1:0] inc_i,
    output logic [SCORE_W-1:0] sum_o
);
    logic [SCORE_W:0] sum_w;

    // Widen, add, then clamp at the display ceiling.
    always_comb begin
        sum_w = {1'b0, score_i} + {1'b0, inc_i};
        if (sum_w > (SCORE_W+1)'(MAX_SCORE)) begin
            sum_o = SCORE_W'(MAX_SCORE);
        end else begin
            sum_o = sum_w[SCORE_W-1:0];
        end
    end
endmodule

// File: rtl/score_keeper.sv
// Run score and high-score tracker feeding the score display.
// FSM IDLE -> PLAY -> COMMIT -> OVER; all outputs registered.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE = MAX_SCORE_DEF,
    parameter int unsigned BONUS_PTS = BONUS_PTS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    score_keeper_if.slave  bus
);
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               rec_q, rec_d;
    logic               playing_q, playing_d;
    logic [SCORE_W-1:0] inc_w;
    logic [SCORE_W-1:0] sum_w;

    // Points earned this cycle from the two pulse sources.
    always_comb begin
        inc_w = (bus.point ? SCORE_W'(1) : SCORE_W'(0))
              + (bus.bonus ? SCORE_W'(BONUS_PTS) : SCORE_W'(0));
    end

    score_sat_add #(
        .MAX_SCORE (MAX_SCORE)
    ) u_sat (
        .score_i (score_q),
        .inc_i   (inc_w),
        .sum_o   (sum_w)
    );

    // Next-state and next-output logic for the run FSM.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        rec_d   = rec_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    score_d = '0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                score_d = sum_w;
                if (bus.game_over) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (score_q > high_q) begin
                    high_d = score_q;
                    rec_d  = 1'b1;
                end
                state_d = OVER;
            end
            OVER: begin
                if (bus.start) begin
                    score_d = '0;
                    rec_d   = 1'b0;
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clearing the high score wins over a same-cycle commit.
        if (bus.clr_high) begin
            high_d = '0;
            if (state_q == COMMIT) begin
                rec_d = 1'b0;
            end
        end
        playing_d = (state_d == PLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            score_q   <= '0;
            high_q    <= '0;
            rec_q     <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            rec_q     <= rec_d;
            playing_q <= playing_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.score_high = high_q;
    assign bus.new_record = rec_q;
    assign bus.playing    = playing_q;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper and its saturating adder.
// A behavioural model queues expected outputs per driven cycle.
module tb_score_keeper;
    import score_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    score_keeper_if sk ();

    score_keeper u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sk)
    );

    logic [6:0] sa;
    logic [6:0] si;
    logic [6:0] so;

    score_sat_add #(.MAX_SCORE(99)) u_sat (
        .score_i (sa),
        .inc_i   (si),
        .sum_o   (so)
    );

    typedef struct packed {
        logic [6:0] score;
        logic [6:0] high;
        logic       rec;
        logic       play;
    } exp_t;

    exp_t q[$];
    int n_tot = 0;
    int n_bad = 0;
    int m_st = 0;
    int m_score = 0;
    int m_high = 0;
    int m_rec = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: 0 idle, 1 play, 2 commit, 3 over.
    task automatic model(input logic s, p, b, g, c);
        exp_t e;
        int st0;
        int inc;
        st0 = m_st;
        case (m_st)
            0: if (s) begin m_score = 0; m_st = 1; end
            1: begin
                inc = (p ? 1 : 0) + (b ? 5 : 0);
                m_score = (m_score + inc > 99) ? 99 : m_score + inc;
                if (g) m_st = 2;
            end
            2: begin
                if (c) begin
                    m_high = 0;
                    m_rec = 0;
                end else if (m_score > m_high) begin
                    m_high = m_score;
                    m_rec = 1;
                end
                m_st = 3;
            end
            default: if (s) begin m_score = 0; m_rec = 0; m_st = 1; end
        endcase
        if (c && st0 != 2) m_high = 0;
        e.score = 7'(m_score);
        e.high  = 7'(m_high);
        e.rec   = (m_rec != 0);
        e.play  = (m_st == 1);
        q.push_back(e);
    endtask

    task automatic cyc(input logic s, p, b, g, c);
        exp_t e;
        sk.start     = s;
        sk.point     = p;
        sk.bonus     = b;
        sk.game_over = g;
        sk.clr_high  = c;
        model(s, p, b, g, c);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = q.pop_front();
            chk("score", int'(sk.score), int'(e.score));
            chk("high", int'(sk.score_high), int'(e.high));
            chk("rec", int'(sk.new_record), int'(e.rec));
            chk("play", int'(sk.playing), int'(e.play));
        end
    endtask

    task automatic pts(input int n);
        repeat (n) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic bon(input int n);
        repeat (n) cyc(0, 0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic go();
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic beg();
        cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        sk.start     = 1'b0;
        sk.point     = 1'b0;
        sk.bonus     = 1'b0;
        sk.game_over = 1'b0;
        sk.clr_high  = 1'b0;

        for (int a = 0; a < 128; a++) begin
            for (int i = 0; i < 8; i++) begin
                sa = 7'(a);
                si = 7'(i);
                #1;
                chk("sat", int'(so), (a + i > 99) ? 99 : a + i);
            end
        end

        @(negedge clk);
        chk("rst_score", int'(sk.score), 0);
        chk("rst_high", int'(sk.score_high), 0);
        chk("rst_rec", int'(sk.new_record), 0);
        chk("rst_play", int'(sk.playing), 0);
        rst = 1'b0;

        pts(2);
        chk("idle_pt", int'(sk.score), 0);
        beg();
        pts(12);
        chk("run12", int'(sk.score), 12);
        chk("run12_play", int'(sk.playing), 1);
        go();
        chk("commit_play", int'(sk.playing), 0);
        idle(1);
        chk("hi12", int'(sk.score_high), 12);
        chk("rec12", int'(sk.new_record), 1);
        idle(1);

        beg();
        bon(19);
        pts(2);
        chk("s97", int'(sk.score), 97);
        bon(1);
        chk("sat99", int'(sk.score), 99);
        pts(1);
        chk("hold99", int'(sk.score), 99);
        go();
        idle(2);
        chk("hi99", int'(sk.score_high), 99);
        cyc(0, 0, 0, 0, 1);
        chk("clr_over", int'(sk.score_high), 0);

        beg();
        bon(2);
        cyc(0, 1, 1, 0, 0);
        chk("pb16", int'(sk.score), 16);
        cyc(1, 1, 0, 0, 0);
        chk("start_in_play", int'(sk.score), 17);
        pts(3);
        cyc(0, 1, 0, 1, 0);
        idle(2);
        chk("hi21", int'(sk.score_high), 21);

        cyc(0, 0, 0, 0, 1);
        beg();
        bon(6);
        go();
        idle(2);
        chk("hi30", int'(sk.score_high), 30);
        beg();
        bon(6);
        go();
        idle(2);
        chk("eq_hi", int'(sk.score_high), 30);
        chk("eq_rec", int'(sk.new_record), 0);
        beg();
        bon(5);
        go();
        idle(2);
        chk("lt_hi", int'(sk.score_high), 30);
        chk("lt_rec", int'(sk.new_record), 0);
        beg();
        chk("keep_hi", int'(sk.score_high), 30);

        go();
        idle(2);
        cyc(0, 0, 0, 0, 1);
        beg();
        bon(2);
        go();
        idle(2);
        chk("hi10", int'(sk.score_high), 10);
        beg();
        bon(8);
        go();
        cyc(0, 0, 0, 0, 1);
        chk("clr_commit_hi", int'(sk.score_high), 0);
        chk("clr_commit_rec", int'(sk.new_record), 0);
        idle(1);

        beg();
        bon(12);
        go();
        idle(2);
        chk("hi60", int'(sk.score_high), 60);
        beg();
        bon(11);
        chk("s55", int'(sk.score), 55);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_score", int'(sk.score), 0);
        chk("mid_rst_high", int'(sk.score_high), 0);
        chk("mid_rst_rec", int'(sk.new_record), 0);
        chk("mid_rst_play", int'(sk.playing), 0);
        m_st = 0;
        m_score = 0;
        m_high = 0;
        m_rec = 0;
        #2;
        rst = 1'b0;
        pts(1);
        chk("pt_no_start", int'(sk.score), 0);

        for (int k = 0; k < 300; k++) begin
            cyc(($urandom_range(7) == 0), ($urandom_range(1) == 0),
                ($urandom_range(3) == 0), ($urandom_range(15) == 0),
                ($urandom_range(31) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
# score_keeper

Sequential score and high-score tracker for the game datapath. It sits directly upstream of the two-digit seven-segment score display and drives that display's 7-bit `score` and `score_high` inputs. It accumulates points during a run and saturates at the display limit of 99. At game over it commits a new high score and flags a new record.

## Interface
Parameters:
- `MAX_SCORE`, 99: saturation ceiling; must be ≤ 99 because the display shows two decimal digits.
- `BONUS_PTS`, 5: increment applied by `bonus`.

Ports:
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: single-cycle pulse that begins a new run.
- `point`, input, 1: single-cycle pulse that adds 1 point.
- `bonus`, input, 1: single-cycle pulse that adds `BONUS_PTS` points.
- `game_over`, input, 1: single-cycle pulse that ends the run.
- `clr_high`, input, 1: single-cycle pulse that clears the high score.
- `score`, output, 7: current run score, 0..`MAX_SCORE`, registered.
- `score_high`, output, 7: best committed score, 0..`MAX_SCORE`, registered.
- `new_record`, output, 1: set when the last committed run beat `score_high`; held until the next `start`.
- `playing`, output, 1: high while in PLAY.

## Operation
- All inputs are synchronous to `clk` and already debounced and edge-converted upstream. A level held high is counted on every cycle it is high.
- FSM states:
  - IDLE: reset state. `start` → clear `score`, go to PLAY.
  - PLAY: scoring is active. `game_over` → COMMIT.
  - COMMIT: lasts exactly one cycle. If `score > score_high`, load `score_high <= score` and set `new_record`. Always go to OVER.
  - OVER: `score` and `score_high` hold. `start` → clear `score`, clear `new_record`, go to PLAY.
- Increment in PLAY: `inc = point*1 + bonus*BONUS_PTS`. When both pulse in the same cycle, `inc = 1 + BONUS_PTS`.
- Saturation: `score_next = min(score + inc, MAX_SCORE)`. Compute the sum at 8 bits so it cannot wrap.
- `point` or `bonus` arriving in the same cycle as `game_over` is counted first. COMMIT then uses the updated score.
- `start` during PLAY or COMMIT is ignored; no restart without a commit. `game_over` outside PLAY is ignored. `point` and `bonus` outside PLAY are ignored.
- `clr_high` is accepted in any state and sets `score_high <= 0`.
  - In COMMIT, `clr_high` has priority: `score_high = 0` and `new_record = 0`.
  - `clr_high` does not affect `score` or the state.
- Equal score is not a record: `score == score_high` leaves both `score_high` and `new_record` unchanged.

## Timing
- Reset values, applied immediately on `rst` asserting: state IDLE, `score = 0`, `score_high = 0`, `new_record = 0`, `playing = 0`.
- Reset asserted mid-run discards both the run and the high score.
- `start` at edge N: `score = 0` and `playing = 1` visible after edge N.
- `point` or `bonus` sampled at edge N: the updated `score` is visible after edge N, giving one cycle of latency.
- `game_over` at edge N: the FSM is in COMMIT after edge N, and `playing = 0` from then on. `score_high` and `new_record` update after edge N+1, giving two cycles from `game_over`.
- Outputs are registered only, with no combinational paths from inputs to outputs.

## Structure
- Shared package `score_pkg` holds:
  - the state typedef (IDLE, PLAY, COMMIT, OVER);
  - the `MAX_SCORE` and `BONUS_PTS` defaults;
  - the score width constant, 7.
- One combinational sub-module, `score_sat_add`: 7-bit score in, increment in, saturated 7-bit sum out. Verify it standalone for exhaustive score × inc.
- The FSM and registers stay in the top module.

## Test plan
- Reset then `start` followed by 12 `point` pulses → `score = 12`, `score_high = 0`, `playing = 1`. Then `game_over` → after 2 cycles `score_high = 12`, `new_record = 1`, `playing = 0`.
- From `score = 97`, apply `bonus` → `score = 99`. A further `point` → `score` stays at 99.
- `point` and `bonus` in the same cycle from `score = 10` → `score = 16`. `point` and `game_over` in the same cycle at `score = 20` → committed `score_high = 21`.
- `score_high = 30`:
  - a run ending at 30 → `score_high = 30`, `new_record = 0`;
  - a run ending at 25 → `score_high = 30`, `new_record = 0`;
  - the next `start` keeps `score_high = 30`.
- `clr_high` on the COMMIT cycle of a run scoring 40 (old `score_high = 10`) → `score_high = 0`, `new_record = 0`.
- `rst` pulsed mid-run at `score = 55`, `score_high = 60` → all outputs 0 immediately. `point` after reset, without `start` → `score` stays 0.
